autoc_moving_sum: RTL

AUTOC_MOVING_SUM -- requirements
Module: autoc_moving_sum

---
 rtl/autoc_pkg.sv | 19 +
 rtl/autoc_window_ram.sv | 30 +++
 rtl/autoc_moving_sum.sv | 129 ++++++++++++
 3 files changed

// File: rtl/autoc_pkg.sv
// Shared definitions for the autocorrelation stages: window sizing helpers
// and the FILL/RUN window state encoding.
package autoc_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } win_state_e;

  function automatic int win_len(input int log2_len);
    return 1 << log2_len;
  endfunction

  // Summing 2**log2_len words of prod_width bits can never exceed this width.
  function automatic int sum_width(input int prod_width, input int log2_len);
    return prod_width + log2_len;
  endfunction

endpackage

// File: rtl/autoc_window_ram.sv
// Window storage for the moving sum: one write port, and one asynchronous
// read port that returns the slot at the write address before it is overwritten.
module autoc_window_ram
  import autoc_pkg::*;
#(
  parameter int WIDTH  = 31,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  localparam int Depth = win_len(ADDR_W);

  logic [WIDTH-1:0] mem_q [Depth];

  // NOTE: the storage array has no reset; the owner masks stale entries
  // while the window fills, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/autoc_moving_sum.sv
// Moving sum over the last 2**LOG2_LEN signed products, with a hold-count
// threshold detector driven by each valid (window-full) sum.
module autoc_moving_sum
  import autoc_pkg::*;
#(
  parameter int PROD_WIDTH = 31,
  parameter int LOG2_LEN   = 5,
  parameter int HOLD       = 4
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             clear,
  input  logic signed [PROD_WIDTH-1:0]                     prod_in,
  input  logic                                             prod_strobe,
  input  logic signed [sum_width(PROD_WIDTH, LOG2_LEN)-1:0] threshold,
  output logic signed [sum_width(PROD_WIDTH, LOG2_LEN)-1:0] sum_out,
  output logic                                             sum_strobe,
  output logic                                             det_level,
  output logic                                             det_pulse
);

  localparam int SumW  = sum_width(PROD_WIDTH, LOG2_LEN);
  localparam int HoldW = $clog2(HOLD + 1);
  localparam logic [LOG2_LEN-1:0] PtrLast = '1;
  localparam logic [HoldW-1:0]    HoldMax = HoldW'(HOLD);

  win_state_e                state_q, state_d;
  logic [LOG2_LEN-1:0]       ptr_q, ptr_d;
  logic signed [SumW-1:0]    acc_q, acc_d;
  logic [HoldW-1:0]          hold_q, hold_d;
  logic                      sum_strobe_q, sum_strobe_d;
  logic                      det_level_q, det_level_d;
  logic                      det_pulse_q, det_pulse_d;

  logic                      accept;
  logic                      window_full;
  logic [PROD_WIDTH-1:0]     ram_rd;
  logic signed [SumW-1:0]    prod_ext;
  logic signed [SumW-1:0]    old_ext;

  assign accept      = prod_strobe & ~clear;
  assign window_full = (state_q == ST_RUN) || (ptr_q == PtrLast);

  autoc_window_ram #(
    .WIDTH  (PROD_WIDTH),
    .ADDR_W (LOG2_LEN)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (accept),
    .addr_i    (ptr_q),
    .wr_data_i (prod_in),
    .rd_data_o (ram_rd)
  );

  // During FILL the pointer equals the fill count, and the slot being read
  // holds nothing from this window, so it contributes zero.
  assign prod_ext = {{LOG2_LEN{prod_in[PROD_WIDTH-1]}}, prod_in};
  assign old_ext  = (state_q == ST_RUN) ? {{LOG2_LEN{ram_rd[PROD_WIDTH-1]}}, ram_rd} : '0;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    acc_d        = acc_q;
    hold_d       = hold_q;
    det_level_d  = det_level_q;
    sum_strobe_d = 1'b0;
    det_pulse_d  = 1'b0;

    if (clear) begin
      state_d     = ST_FILL;
      ptr_d       = '0;
      acc_d       = '0;
      hold_d      = '0;
      det_level_d = 1'b0;
    end else if (prod_strobe) begin
      acc_d        = acc_q + prod_ext - old_ext;
      ptr_d        = ptr_q + 1'b1;
      sum_strobe_d = window_full;
      if (ptr_q == PtrLast) begin
        state_d = ST_RUN;
      end

      if (window_full) begin
        if (acc_d >= threshold) begin
          if (hold_q != HoldMax) begin
            hold_d = hold_q + 1'b1;
          end
          if ((hold_d == HoldMax) && !det_level_q) begin
            det_level_d = 1'b1;
            det_pulse_d = 1'b1;
          end
        end else begin
          hold_d      = '0;
          det_level_d = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      ptr_q        <= '0;
      acc_q        <= '0;
      hold_q       <= '0;
      sum_strobe_q <= 1'b0;
      det_level_q  <= 1'b0;
      det_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      acc_q        <= acc_d;
      hold_q       <= hold_d;
      sum_strobe_q <= sum_strobe_d;
      det_level_q  <= det_level_d;
      det_pulse_q  <= det_pulse_d;
    end
  end

  assign sum_out    = acc_q;
  assign sum_strobe = sum_strobe_q;
  assign det_level  = det_level_q;
  assign det_pulse  = det_pulse_q;

endmodule
